// File: rtl/pc_fetch.sv
// Program counter and instruction fetch for picoMIPS: fetches a word over req/ack,
// holds it for the decoder, then applies the decoder's PC controls and counts retirement.
module pc_fetch #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Isize = 24,
  parameter int unsigned Csize = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic [Psize-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [Isize-1:0] mem_data,
  output logic [Isize-1:0] instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  input  logic             stall,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [Psize-1:0] branch_addr,
  input  logic [Psize-1:0] branch_off,
  output logic [Psize-1:0] pc,
  output logic [Csize-1:0] retired
);

  typedef enum logic [1:0] {
    StRst   = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2
  } state_e;

  localparam logic [Psize-1:0] PcOne      = {{(Psize-1){1'b0}}, 1'b1};
  localparam logic [Csize-1:0] RetiredOne = {{(Csize-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [Psize-1:0] pc_q, pc_d;
  logic [Isize-1:0] instr_q, instr_d;
  logic [Csize-1:0] retired_q, retired_d;
  logic [Psize-1:0] next_pc;

  // branch_off is already Psize wide, so a plain modular add is the sign-extended add.
  always_comb begin
    next_pc = pc_q;
    if (PCabsbranch) begin
      next_pc = branch_addr;
    end else if (PCrelbranch) begin
      next_pc = pc_q + branch_off;
    end else if (PCincr) begin
      next_pc = pc_q + PcOne;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      StRst: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          instr_d = mem_data;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!stall) begin
          pc_d      = next_pc;
          retired_d = retired_q + RetiredOne;
          state_d   = StFetch;
        end
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRst;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign mem_req     = (state_q == StFetch);
  assign instr_valid = (state_q == StExec);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;
  assign opcode      = instr_q[Isize-1 -: 6];

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: scoreboard queues hold expected fetch addresses and
// instruction words, popped when the DUT presents a fetch or a valid instruction.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [5:0]  mem_addr;
  logic        mem_ack;
  logic [23:0] mem_data;
  logic [23:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        stall;
  logic        PCincr;
  logic        PCabsbranch;
  logic        PCrelbranch;
  logic [5:0]  branch_addr;
  logic [5:0]  branch_off;
  logic [5:0]  pc;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  exp_addr_q[$];
  logic [23:0] exp_instr_q[$];
  logic [5:0]  cur_addr;
  logic [23:0] cur_instr;
  logic [15:0] m_retired;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .stall      (stall),
    .PCincr     (PCincr),
    .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch),
    .branch_addr(branch_addr),
    .branch_off (branch_off),
    .pc         (pc),
    .retired    (retired)
  );

  // Address 0 holds 24'h04_0000; every address holds a distinct word.
  function automatic logic [23:0] rom_word(input logic [5:0] a);
    return {a + 6'd1, a, 6'h00, a};
  endfunction

  assign mem_data = rom_word(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in FETCH; acks after 'wait_cycles' idle cycles.
  task automatic fetch(input int wait_cycles);
    cur_addr = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 6'bx;
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'(cur_addr));
    check("fetch_not_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      check("wait_req", 32'(mem_req), 32'd1);
      check("wait_addr", 32'(mem_addr), 32'(cur_addr));
      check("wait_not_valid", 32'(instr_valid), 32'd0);
    end
    mem_ack = 1'b1;
    exp_instr_q.push_back(rom_word(cur_addr));
    tick();
    mem_ack = 1'b0;
    cur_instr = (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 24'bx;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req", 32'(mem_req), 32'd0);
    check("exec_instr", 32'(instr), 32'(cur_instr));
    check("exec_opcode", 32'(opcode), 32'(cur_instr[23:18]));
  endtask

  // Entered in EXEC; applies PC controls for one cycle, 'target' is the expected next pc.
  task automatic exec(input logic incr, input logic abs_b, input logic rel_b,
                      input logic [5:0] baddr, input logic [5:0] boff, input logic [5:0] target);
    PCincr      = incr;
    PCabsbranch = abs_b;
    PCrelbranch = rel_b;
    branch_addr = baddr;
    branch_off  = boff;
    exp_addr_q.push_back(target);
    m_retired++;
    tick();
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
    PCrelbranch = 1'b0;
    check("next_pc", 32'(pc), 32'(target));
    check("retired", 32'(retired), 32'(m_retired));
  endtask

  task automatic stall_cycles(input int n);
    stall  = 1'b1;
    PCincr = 1'b1;
    PCabsbranch = 1'b1;
    branch_addr = 6'd20;
    for (int i = 0; i < n; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_req", 32'(mem_req), 32'd0);
      check("stall_instr", 32'(instr), 32'(cur_instr));
      check("stall_pc", 32'(pc), 32'(cur_addr));
      check("stall_retired", 32'(retired), 32'(m_retired));
    end
    stall       = 1'b0;
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; stall = 1'b0;
    PCincr = 1'b0; PCabsbranch = 1'b0; PCrelbranch = 1'b0;
    branch_addr = '0; branch_off = '0; m_retired = '0;

    tick();
    tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    reset = 1'b0;
    tick();
    exp_addr_q.push_back(6'd0);

    fetch(0);
    check("first_word", 32'(instr), 32'h04_0000);
    check("first_opcode", 32'(opcode), 32'h01);
    exec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd1);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd5, 6'd0, 6'd5);
    fetch(3); exec(1'b0, 1'b1, 1'b0, 6'd10, 6'd0, 6'd10);
    fetch(0); exec(1'b0, 1'b0, 1'b1, 6'd0, 6'h3E, 6'd8);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd10, 6'd0, 6'd10);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd33, 6'd0, 6'd33);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd10, 6'd0, 6'd10);
    fetch(0); exec(1'b1, 1'b1, 1'b1, 6'd33, 6'h3E, 6'd33);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd63, 6'd0, 6'd63);
    fetch(0); exec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);
    fetch(0); exec(1'b0, 1'b1, 1'b0, 6'd1, 6'd0, 6'd1);
    fetch(0); exec(1'b0, 1'b0, 1'b1, 6'd0, 6'h3C, 6'd61);
    fetch(1); stall_cycles(4); exec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd62);
    fetch(0); exec(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd62);
    fetch(0); exec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd63);

    // Reset lands in FETCH together with an ack; the ack must be dropped.
    check("pre_rst_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    reset   = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_instr", 32'(instr), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_pc", 32'(pc), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(6'd0);
    m_retired = '0;
    fetch(0);
    exec(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
